// File: rtl/aes_pkg.sv
// Shared AES constants, byte/word helpers and the key-walker state type.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_EMIT,
        ST_BWD
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is never used by the schedule; entries past 10 pad the table
    // so any 4-bit index is in range.
    localparam logic [7:0] RCON [16] = '{
        8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// One key-schedule word step: y = w_far ^ f(x, i). Used for both directions.
module aes_key_word_step
    import aes_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic [31:0] x,
    input  logic [5:0]  i,
    input  logic [31:0] w_far,
    output logic [31:0] y
);

    localparam logic [5:0] NK_W = 6'(Nk);

    logic [5:0]  rem;
    logic [3:0]  quo;
    logic [31:0] f;

    // Word function; the round constant lands in the first (most significant) key byte
    always_comb begin
        rem = i % NK_W;
        quo = 4'(i / NK_W);
        if (rem == '0) begin
            f = sub_word(rot_word(x)) ^ {RCON[quo], 24'h0};
        end else if (Nk > 6 && rem == 6'd4) begin
            f = sub_word(x);
        end else begin
            f = x;
        end
        y = w_far ^ f;
    end

endmodule

// File: rtl/aes_key_reverse.sv
// Walks the AES key schedule forward to the last round key, then streams
// round keys Nr..0 while stepping the schedule back through an Nk-word window.
module aes_key_reverse
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [32*Nk-1:0]  key,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [127:0]      rk,
    output logic [3:0]        rk_idx,
    output logic              rk_last
);

    localparam int unsigned NKU   = Nk;
    localparam logic [5:0]  NK_W  = 6'(Nk);
    localparam logic [5:0]  J_TOP = 6'(4 * (Nr + 1) - Nk);

    state_t       state_q, state_d;
    logic [31:0]  win_q [Nk];
    logic [31:0]  win_d [Nk];
    logic [5:0]   j_q, j_d;
    logic [3:0]   r_q, r_d;
    logic [3:0]   r_dec;
    logic         rk_valid_q, rk_valid_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         rk_last_q, rk_last_d;
    logic         load_rk;
    logic [5:0]   off;

    logic [5:0]   step_i;
    logic [31:0]  step_x, step_far, step_y;

    aes_key_word_step #(.Nk(Nk)) u_step (
        .x     (step_x),
        .i     (step_i),
        .w_far (step_far),
        .y     (step_y)
    );

    // Step operands: forward builds w[j+Nk], backward recovers w[j-1]
    always_comb begin
        if (state_q == ST_BWD) begin
            step_i   = j_q + NK_W - 6'd1;
            step_x   = win_q[Nk-2];
            step_far = win_q[Nk-1];
        end else begin
            step_i   = j_q + NK_W;
            step_x   = win_q[Nk-1];
            step_far = win_q[0];
        end
    end

    // Next-state, window shift and counter updates
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        j_d        = j_q;
        r_d        = r_q;
        rk_valid_d = rk_valid_q;
        load_rk    = 1'b0;
        r_dec      = r_q - 4'd1;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    for (int unsigned k = 0; k < NKU; k++) begin
                        win_d[k] = key[32*k +: 32];
                    end
                    j_d     = '0;
                    r_d     = '0;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                for (int unsigned k = 0; k < NKU - 1; k++) begin
                    win_d[k] = win_q[k+1];
                end
                win_d[Nk-1] = step_y;
                j_d         = j_q + 6'd1;
                if (j_q + 6'd1 == J_TOP) begin
                    r_d        = 4'(Nr);
                    state_d    = ST_EMIT;
                    rk_valid_d = 1'b1;
                    load_rk    = 1'b1;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (r_q == '0) begin
                        state_d    = ST_IDLE;
                        rk_valid_d = 1'b0;
                    end else begin
                        r_d = r_dec;
                        if ({r_dec, 2'b00} >= j_q) begin
                            load_rk = 1'b1;
                        end else begin
                            state_d    = ST_BWD;
                            rk_valid_d = 1'b0;
                        end
                    end
                end
            end
            ST_BWD: begin
                for (int unsigned k = NKU - 1; k > 0; k--) begin
                    win_d[k] = win_q[k-1];
                end
                win_d[0] = step_y;
                j_d      = j_q - 6'd1;
                if (j_q - 6'd1 == {r_q, 2'b00}) begin
                    state_d    = ST_EMIT;
                    rk_valid_d = 1'b1;
                    load_rk    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Round-key output capture: words 4r..4r+3 sit at window offset 4r-j
    always_comb begin
        rk_d      = rk_q;
        rk_idx_d  = rk_idx_q;
        rk_last_d = rk_last_q;
        off       = {r_d, 2'b00} - j_d;
        if (load_rk) begin
            for (int unsigned k = 0; k < 4; k++) begin
                for (int unsigned m = 0; m < NKU; m++) begin
                    if (6'(m) == off + 6'(k)) begin
                        rk_d[32*k +: 32] = win_d[m];
                    end
                end
            end
            rk_idx_d  = r_d;
            rk_last_d = (r_d == '0);
        end
    end

    // State, window, counters and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int unsigned k = 0; k < NKU; k++) begin
                win_q[k] <= '0;
            end
            j_q        <= '0;
            r_q        <= '0;
            rk_valid_q <= 1'b0;
            rk_q       <= '0;
            rk_idx_q   <= '0;
            rk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            j_q        <= j_d;
            r_q        <= r_d;
            rk_valid_q <= rk_valid_d;
            rk_q       <= rk_d;
            rk_idx_q   <= rk_idx_d;
            rk_last_q  <= rk_last_d;
        end
    end

    assign key_ready = (state_q == ST_IDLE);
    assign rk_valid  = rk_valid_q;
    assign rk        = rk_q;
    assign rk_idx    = rk_idx_q;
    assign rk_last   = rk_last_q;

endmodule

// File: tb/tb_aes_key_reverse.sv
// Bench for aes_key_reverse: one instance per key length, checked against a
// software AES key expansion with an S-box derived from GF(2^8) arithmetic.
module tb_aes_key_reverse;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    int           sel;
    logic         kv, rr;
    logic [255:0] key_bus;

    logic         kr4, kr6, kr8, rv4, rv6, rv8, rl4, rl6, rl8;
    logic [127:0] rk4, rk6, rk8;
    logic [3:0]   ri4, ri6, ri8;

    logic         o_kr, o_rv, o_last;
    logic [127:0] o_rk;
    logic [3:0]   o_idx;

    aes_key_reverse #(.Nk(4), .Nr(10)) u_k4 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv && sel == 4), .key_ready(kr4),
        .key(key_bus[127:0]), .rk_valid(rv4), .rk_ready(rr && sel == 4),
        .rk(rk4), .rk_idx(ri4), .rk_last(rl4)
    );
    aes_key_reverse #(.Nk(6), .Nr(12)) u_k6 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv && sel == 6), .key_ready(kr6),
        .key(key_bus[191:0]), .rk_valid(rv6), .rk_ready(rr && sel == 6),
        .rk(rk6), .rk_idx(ri6), .rk_last(rl6)
    );
    aes_key_reverse #(.Nk(8), .Nr(14)) u_k8 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv && sel == 8), .key_ready(kr8),
        .key(key_bus), .rk_valid(rv8), .rk_ready(rr && sel == 8),
        .rk(rk8), .rk_idx(ri8), .rk_last(rl8)
    );

    always_comb begin
        case (sel)
            4: begin o_kr = kr4; o_rv = rv4; o_rk = rk4; o_idx = ri4; o_last = rl4; end
            6: begin o_kr = kr6; o_rv = rv6; o_rk = rk6; o_idx = ri6; o_last = rl6; end
            default: begin o_kr = kr8; o_rv = rv8; o_rk = rk8; o_idx = ri8; o_last = rl8; end
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [7:0]  sbox_m [256];
    bit [31:0] mw [60];

    function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
        bit [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic bit [7:0] rotl8(input bit [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            bit [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic bit [31:0] msub(input bit [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    task automatic build_schedule(input int nk, input logic [255:0] k);
        int nr = nk + 6;
        bit [7:0] rc = 8'h01;
        for (int i = 0; i < nk; i++) mw[i] = k[32*i +: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            bit [31:0] t = mw[i-1];
            if (i % nk == 0) begin
                t = msub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end else if (nk > 6 && i % nk == 4) begin
                t = msub(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    // ---------------- stimulus ----------------
    // rnd_ready: random rk_ready; poke: key_valid pulses in FWD and EMIT;
    // rst_mid: one-cycle reset right after round Nr is taken
    task automatic run_stream(input int nk, input logic [255:0] k, input bit rnd_ready,
                              input bit poke, input bit rst_mid, input bit use_kat,
                              input logic [127:0] kat);
        int nr = nk + 6;
        int lat = 0;
        int cyc = 0;
        int r;
        int last_hs = 0;
        bit stalled = 0;
        logic [127:0] s_rk;
        logic [3:0]   s_idx;
        logic         s_last;
        int wait_n = 0;

        sel = nk;
        build_schedule(nk, k);
        @(negedge clk);
        while (!o_kr && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!o_kr) begin
            check("key_ready_wait", 128'(o_kr), 128'd1);
            return;
        end
        key_bus = k;
        kv = 1'b1;
        rr = 1'b0;
        @(posedge clk);
        #1 kv = 1'b0;

        forever begin
            @(negedge clk);
            kv = 1'b0;
            if (o_rv || lat > 200) break;
            lat++;
            if (poke && lat == 5) begin
                kv = 1'b1;
                check("key_ready_fwd", 128'(o_kr), 128'd0);
            end
        end
        check($sformatf("first_latency_nk%0d", nk), 128'(lat), 128'(4 * (nr + 1) - nk));
        if (!o_rv) return;
        if (use_kat) check($sformatf("kat_round%0d", nr), o_rk, kat);

        r = nr;
        while (r >= 0 && cyc < 3000) begin
            kv = 1'b0;
            if (rst_mid && r == nr - 1) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_key_ready", 128'(o_kr), 128'd1);
                check("rst_rk_valid", 128'(o_rv), 128'd0);
                check("rst_rk", o_rk, 128'd0);
                check("rst_rk_idx", 128'(o_idx), 128'd0);
                check("rst_rk_last", 128'(o_last), 128'd0);
                rst_n = 1'b1;
                return;
            end
            if (o_rv) begin
                if (stalled) begin
                    check("stall_rk", o_rk, s_rk);
                    check("stall_idx", 128'(o_idx), 128'(s_idx));
                    check("stall_last", 128'(o_last), 128'(s_last));
                end
                rr = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (poke && r == nr - 1) begin
                    kv = 1'b1;
                    check("key_ready_emit", 128'(o_kr), 128'd0);
                end
                if (rr) begin
                    check($sformatf("rk_nk%0d_r%0d", nk, r), o_rk,
                          {mw[4*r+3], mw[4*r+2], mw[4*r+1], mw[4*r]});
                    check($sformatf("idx_nk%0d_r%0d", nk, r), 128'(o_idx), 128'(r));
                    check($sformatf("last_nk%0d_r%0d", nk, r), 128'(o_last), 128'(r == 0));
                    if (use_kat && nk == 4 && r == 0) check("final_is_key", o_rk, k[127:0]);
                    if (!rnd_ready && nk == 8 && r == 13) check("b2b_14_13", 128'(cyc - last_hs), 128'd1);
                    if (!rnd_ready && nk == 4 && r < nr) check("gap_nk4", 128'(cyc - last_hs), 128'd5);
                    last_hs = cyc;
                    stalled = 1'b0;
                    r--;
                end else begin
                    stalled = 1'b1;
                    s_rk    = o_rk;
                    s_idx   = o_idx;
                    s_last  = o_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        kv = 1'b0;
        rr = 1'b0;
        if (r >= 0) begin
            check("stream_timeout", 128'(r + 1), 128'd0);
        end else begin
            check("key_ready_after_r0", 128'(o_kr), 128'd1);
            check("rk_valid_after_r0", 128'(o_rv), 128'd0);
        end
    endtask

    localparam logic [255:0] KEY4 = 256'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [255:0] KEY6 = 256'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7;
    localparam logic [255:0] KEY8 = 256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;
    localparam logic [127:0] KAT4 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
    localparam logic [127:0] KAT6 = 128'h01002202_8ecc7204_448c773c_e98ba06f;
    localparam logic [127:0] KAT8 = 128'h706c631e_046df344_e6188d0b_fe4890d1;

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
        return k;
    endfunction

    initial begin
        rst_n   = 1'b0;
        kv      = 1'b0;
        rr      = 1'b0;
        sel     = 4;
        key_bus = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        for (int s = 4; s <= 8; s += 2) begin
            sel = s;
            #1;
            check($sformatf("reset_key_ready_nk%0d", s), 128'(o_kr), 128'd1);
            check($sformatf("reset_rk_valid_nk%0d", s), 128'(o_rv), 128'd0);
            check($sformatf("reset_rk_nk%0d", s), {o_rk[123:0], o_idx}, 128'd0);
            check($sformatf("reset_rk_last_nk%0d", s), 128'(o_last), 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_stream(4, KEY4, 1'b0, 1'b0, 1'b0, 1'b1, KAT4);
        run_stream(6, KEY6, 1'b0, 1'b0, 1'b0, 1'b1, KAT6);
        run_stream(8, KEY8, 1'b0, 1'b0, 1'b0, 1'b1, KAT8);
        for (int n = 0; n < 2; n++) begin
            run_stream(4, rand_key(), 1'b1, 1'b0, 1'b0, 1'b0, '0);
            run_stream(6, rand_key(), 1'b1, 1'b0, 1'b0, 1'b0, '0);
            run_stream(8, rand_key(), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        end
        run_stream(6, rand_key(), 1'b1, 1'b1, 1'b0, 1'b0, '0);
        run_stream(4, KEY4, 1'b0, 1'b0, 1'b1, 1'b1, KAT4);
        run_stream(4, KEY4, 1'b0, 1'b0, 1'b0, 1'b1, KAT4);
        run_stream(8, rand_key(), 1'b0, 1'b0, 1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
